md_unit: RTL and testbench
==========================

# md_unit

Parametrised multi-cycle multiply/divide unit with HI/LO result registers, used by the execute stage next to the single-cycle ALU. It accepts one operation per start pulse, holds `busy` for a configurable latency, and writes the result into HI/LO. Over the current fixed 32-bit unit it adds configurable width and latencies, multiply-accumulate/subtract, a defined divide-by-zero and overflow result, a one-cycle `done` pulse, and a `flush` input that aborts an in-flight operation when a younger instruction is squashed.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be 8 or more.
- `MUL_CYCLES`, 5: busy cycles for MULT/MULTU/MADD*/MSUB*; must be 1 or more.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU; must be 1 or more.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: launch the operation on `op`/`a`/`b` at this edge.
- `op` in 4: operation code from `md_pkg`.
- `a` in WIDTH: rs operand (dividend / multiplicand / MTHI-MTLO data).
- `b` in WIDTH: rt operand.
- `flush` in 1: abort the in-flight operation and ignore `start` this cycle.
- `busy` out 1: an operation is in flight.
- `done` out 1: one-cycle pulse; HI/LO updated by a long operation at this edge.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- Ops:
  - MULT/MULTU: {HI,LO} = a*b, signed or unsigned.
  - MADD/MADDU: {HI,LO} += a*b.
  - MSUB/MSUBU: {HI,LO} -= a*b.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - MTHI: HI = a. MTLO: LO = a.
  - NOP: no action.
- `start` is accepted only when `busy`=0 and `flush`=0; otherwise it is ignored. The stall logic must hold the instruction while busy.
- On acceptance, latch `op`, `a` and `b` into internal registers. Inputs may change afterwards.
- MTHI/MTLO write the register at the accepting edge. They do not assert `busy` or `done`.
- MADD*/MSUB* read {HI,LO} at the completion edge, not at the start edge.
- Signed division truncates toward zero. The remainder takes the sign of the dividend.
- Divide by zero: LO = all ones, HI = dividend. No trap.
- Signed overflow (MIN / -1): LO = MIN, HI = 0.
- States:
  - IDLE -> BUSY on accepted long op; counter loaded with the op's latency.
  - BUSY: counter decrements each cycle. When it reaches 1 -> IDLE, HI/LO written and `done` pulsed at that edge.
  - BUSY with `flush`=1 -> IDLE at the next edge. HI/LO unchanged, no `done`.
- `flush` on the completion edge wins: result discarded, no `done`.
- Reset (any time, including mid-operation): `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.

## Timing
- Accept edge E0. `busy`=1 after E0 through edge E_N, where N = MUL_CYCLES or DIV_CYCLES.
- HI/LO take the new value and `done`=1 in the cycle after E_N. `busy`=0 in that same cycle.
- A new `start` is accepted in the same cycle `done`=1 (back-to-back). The next op sees the updated HI/LO.
- MFHI/MFLO reads are combinational from `hi`/`lo`. Reading during `busy` returns the old value; the stall logic prevents this.
- All outputs are registered. No combinational path from `start` to `busy`.

## Structure
- `md_pkg`: op localparams (NOP=0, MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO), the state encoding, and a latency-select function.
- Sub-module `md_arith`: purely combinational. Inputs are the latched op/a/b and the current {HI,LO}. Output is the 2*WIDTH next value, including the divide-by-zero and overflow rules.
- `md_unit` holds the FSM, counter, operand latches and HI/LO registers.

## Test plan
- Reset low mid-DIV -> `busy`=0, `hi`=`lo`=0 immediately. Reset released -> `start` accepted on the first edge.
- MULT a=-3 (0xFFFFFFFD), b=7 -> `busy` for 5 cycles, then `done`. hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7, b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- MTLO 1 then MADDU a=0xFFFFFFFF, b=2 issued back-to-back -> hi=1, lo=0xFFFFFFFF.
- MULTU 2*3 with `flush` on the 3rd busy cycle -> `busy` falls next edge, no `done`, HI/LO unchanged. `start` held during busy -> ignored.
- WIDTH=16, DIV_CYCLES=1: DIVU 100/7 -> one busy cycle, lo=14, hi=2.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - operation codes driven on md_unit.op
//   - FSM state encoding
//   - op_latency(): busy-cycle count for an op (0 = not a long op)
package md_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } md_state_e;

    function automatic int unsigned op_latency(input logic [3:0] op,
                                               input int unsigned mul_cycles,
                                               input int unsigned div_cycles);
        int unsigned lat;
        lat = 0;
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: lat = mul_cycles;
            OP_DIV, OP_DIVU:                                         lat = div_cycles;
            default:                                                 lat = 0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational datapath of the multiply/divide unit.
// Ports:
//   op      latched operation code
//   a, b    latched operands (a = rs, b = rt)
//   hi, lo  current HI/LO (accumulator for MADD*/MSUB*)
//   result  next {HI,LO}; equals {hi,lo} for ops that do not write
// Division: signed quotient truncates toward zero, remainder follows the
// dividend; x/0 gives LO=all ones, HI=dividend; MIN/-1 gives LO=MIN, HI=0.
module md_arith #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] result
);
    import md_pkg::*;

    logic [2*WIDTH-1:0]      acc;
    logic [2*WIDTH-1:0]      prod_s;
    logic [2*WIDTH-1:0]      prod_u;
    logic [2*WIDTH-1:0]      prod;
    logic [WIDTH-1:0]        min_val;
    logic signed [WIDTH-1:0] sq;
    logic signed [WIDTH-1:0] sr;
    logic                    signed_mul;

    always_comb begin
        acc     = {hi, lo};
        min_val = {1'b1, {(WIDTH-1){1'b0}}};
        prod_s  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        signed_mul = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
        prod    = signed_mul ? prod_s : prod_u;
        sq      = '0;
        sr      = '0;
        result  = acc;

        case (op)
            OP_MULT, OP_MULTU: result = prod;
            OP_MADD, OP_MADDU: result = acc + prod;
            OP_MSUB, OP_MSUBU: result = acc - prod;
            OP_DIV: begin
                // The divider is only evaluated on the safe path so the
                // zero-divisor and MIN/-1 cases never reach it.
                if (b == '0) begin
                    result = {a, {WIDTH{1'b1}}};
                end else if ((a == min_val) && (b == '1)) begin
                    result = {{WIDTH{1'b0}}, min_val};
                end else begin
                    sq     = $signed(a) / $signed(b);
                    sr     = $signed(a) % $signed(b);
                    result = {sr, sq};
                end
            end
            OP_DIVU: begin
                if (b == '0) begin
                    result = {a, {WIDTH{1'b1}}};
                end else begin
                    result = {a % b, a / b};
                end
            end
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO result registers.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      launch op/a/b (accepted only when idle and not flushing)
//   op         operation code (md_pkg OP_*)
//   a, b       rs / rt operands
//   flush      abort in-flight op; also blocks start this cycle
//   busy       long op in flight
//   done       one-cycle pulse when HI/LO were written by a long op
//   hi, lo     HI/LO registers
module md_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import md_pkg::*;

    localparam int unsigned MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic [2*WIDTH-1:0] arith_res;
    int unsigned      lat;

    // Accumulating ops see HI/LO as they stand at the completion edge.
    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (arith_res)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        lat     = 0;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    lat = op_latency(op, MUL_CYCLES, DIV_CYCLES);
                    if (lat != 0) begin
                        state_d = ST_BUSY;
                        cnt_d   = CW'(lat);
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    {hi_d, lo_d} = arith_res;
                    done_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ST_BUSY);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start, flush;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start16, flush16;
    logic [3:0]  op16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [15:0] hi16, lo16;

    int n_cmp;
    int n_err;

    md_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    md_unit #(.WIDTH(16), .MUL_CYCLES(3), .DIV_CYCLES(1)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
        .flush(flush16), .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the 32-bit unit; cyc = edges from accept to done (40 = timeout).
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int cyc);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    int  cyc;
    logic seen_done;

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b0; start = 1'b0; flush = 1'b0; op = OP_NOP; a = '0; b = '0;
        start16 = 1'b0; flush16 = 1'b0; op16 = OP_NOP; a16 = '0; b16 = '0;

        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        chk("rst_busy16", 64'(busy16), 64'd0);
        chk("rst_hi16",   64'(hi16),   64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // MULT -3 * 7
        run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7, cyc);
        chk("mult_cycles", 64'(cyc), 64'd5);
        chk("mult_done", 64'(done), 64'd1);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        @(posedge clk); #1;
        chk("done_pulse_one_cycle", 64'(done), 64'd0);

        // DIV -7 / 2
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
        chk("div_cycles", 64'(cyc), 64'd10);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

        // DIVU 5 / 0
        run_op("divz", OP_DIVU, 32'd5, 32'd0, cyc);
        chk("divz_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("divz_hi", 64'(hi), 64'd5);

        // DIV MIN / -1
        run_op("divov", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        chk("divov_lo", 64'(lo), 64'h8000_0000);
        chk("divov_hi", 64'(hi), 64'd0);

        // MTLO 1, then MADDU back-to-back, then MSUBU issued in the done cycle
        op = OP_MTLO; a = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        chk("mtlo_lo", 64'(lo), 64'd1);
        chk("mtlo_hi", 64'(hi), 64'd0);
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_done", 64'(done), 64'd0);
        run_op("maddu", OP_MADDU, 32'hFFFF_FFFF, 32'd2, cyc);
        chk("maddu_cycles", 64'(cyc), 64'd5);
        chk("maddu_hi", 64'(hi), 64'd1);
        chk("maddu_lo", 64'(lo), 64'hFFFF_FFFF);
        run_op("msubu", OP_MSUBU, 32'd1, 32'd1, cyc);
        chk("msubu_hi", 64'(hi), 64'd1);
        chk("msubu_lo", 64'(lo), 64'hFFFF_FFFE);

        // MTHI: immediate write
        op = OP_MTHI; a = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mthi_hi", 64'(hi), 64'd0);

        // MULTU 4*5 with start held and operands changed during busy
        op = OP_MULTU; a = 32'd4; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        a = 32'd9; b = 32'd9;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("hold_cycles", 64'(cyc), 64'd5);
        chk("hold_lo", 64'(lo), 64'd20);
        chk("hold_hi", 64'(hi), 64'd0);

        // MULTU 2*3 flushed on the 3rd busy cycle, start held meanwhile
        op = OP_MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        start = 1'b0; flush = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        chk("flush_no_late_activity", 64'(seen_done), 64'd0);
        chk("flush_lo", 64'(lo), 64'd20);
        chk("flush_hi", 64'(hi), 64'd0);

        // MULTU 2*3 flushed on the completion edge
        op = OP_MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flushend_busy", 64'(busy), 64'd0);
        chk("flushend_done", 64'(done), 64'd0);
        chk("flushend_lo", 64'(lo), 64'd20);

        // Reset mid-DIV, then immediate acceptance after release
        op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        #1;
        reset = 1'b1;
        run_op("postrst", OP_MULTU, 32'd6, 32'd7, cyc);
        chk("postrst_cycles", 64'(cyc), 64'd5);
        chk("postrst_lo", 64'(lo), 64'd42);

        // 16-bit unit, single-cycle divide
        op16 = OP_DIVU; a16 = 16'd100; b16 = 16'd7; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        chk("w16_busy", 64'(busy16), 64'd1);
        @(posedge clk); #1;
        chk("w16_busy_end", 64'(busy16), 64'd0);
        chk("w16_done", 64'(done16), 64'd1);
        chk("w16_lo", 64'(lo16), 64'd14);
        chk("w16_hi", 64'(hi16), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
